timer_unit: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_prescaler.sv | 31 +++
 rtl/timer_unit.sv | 139 +++++++++++++
 tb/tb_timer_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer.
`timescale 1ns/1ps
package timer_pkg;

  // Register offsets, decoded from bus_addr[3:2]
  typedef enum logic [1:0] {
    TMR_CTRL   = 2'b00,
    TMR_LOAD   = 2'b01,
    TMR_COUNT  = 2'b10,
    TMR_STATUS = 2'b11
  } tmr_reg_e;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_AUTO    = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_PSC_LSB = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler for timer_unit: counts 0..psc while enabled and emits a
// tick in the cycle the count equals psc. Used only when TIMER_PRESCALE_EN
// is defined.
`timescale 1ns/1ps
module timer_prescaler #(
  parameter int unsigned PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] cnt_q;

  assign tick = en && (cnt_q == psc);

  // Divider count: held at 0 while disabled or cleared, wraps after a tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped down-counter timer with one-shot / auto-reload modes,
// sticky expiry flag and a one-cycle irq_timer pulse.
// Optional clock prescaler enabled by defining TIMER_PRESCALE_EN.
`timescale 1ns/1ps
module timer_unit
  import timer_pkg::*;
#(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned PSC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_valid,
  input  logic              bus_write,
  input  logic [DATA_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              irq_timer
);

  logic              ctrl_en;
  logic              ctrl_auto;
  logic              ctrl_ie;
  logic [DATA_W-1:0] load_q;
  logic [DATA_W-1:0] count_q;
  logic              exp_q;
  logic              irq_q;

  tmr_reg_e reg_sel;
  logic     wr_ctrl;
  logic     wr_load;
  logic     wr_status;
  logic     rd_en;
  logic     tick_raw;
  logic     tick;
  logic     expire;

  // Only bus_addr[3:2] is decoded; remaining address/data bits are don't-care
  logic unused_bits;
  assign unused_bits = ^{bus_addr[DATA_W-1:4], bus_addr[1:0], bus_wdata};

  assign reg_sel   = tmr_reg_e'(bus_addr[3:2]);
  assign rd_en     = bus_valid && !bus_write;
  assign wr_ctrl   = bus_valid && bus_write && (reg_sel == TMR_CTRL);
  assign wr_load   = bus_valid && bus_write && (reg_sel == TMR_LOAD);
  assign wr_status = bus_valid && bus_write && (reg_sel == TMR_STATUS);

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q;

  timer_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_en),
    .clr   (wr_ctrl),
    .psc   (psc_q),
    .tick  (tick_raw)
  );
`else
  assign tick_raw = ctrl_en;
`endif

  // CTRL/LOAD writes take priority over that cycle's tick
  assign tick   = tick_raw && !wr_ctrl && !wr_load;
  assign expire = tick && (count_q == '0);

  assign irq_timer = irq_q;

  // Register file, counter, sticky flag and interrupt pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_q     <= '0;
`endif
    end else begin
      irq_q <= expire && ctrl_ie;

      if (wr_ctrl) begin
        ctrl_en   <= bus_wdata[CTRL_EN];
        ctrl_auto <= bus_wdata[CTRL_AUTO];
        ctrl_ie   <= bus_wdata[CTRL_IE];
`ifdef TIMER_PRESCALE_EN
        psc_q     <= bus_wdata[CTRL_PSC_LSB +: PSC_W];
`endif
      end else if (expire && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load) begin
        load_q  <= bus_wdata;
        count_q <= bus_wdata;
      end else if (tick) begin
        if (count_q != '0) begin
          count_q <= count_q - 1'b1;
        end else if (ctrl_auto) begin
          count_q <= load_q;
        end
      end

      // Set wins over a coincident write-1-to-clear
      if (expire) begin
        exp_q <= 1'b1;
      end else if (wr_status && bus_wdata[0]) begin
        exp_q <= 1'b0;
      end
    end
  end

  // Combinational read mux; zero unless a read is in progress
  always_comb begin
    bus_rdata = '0;
    if (rd_en) begin
      case (reg_sel)
        TMR_CTRL: begin
          bus_rdata[CTRL_EN]   = ctrl_en;
          bus_rdata[CTRL_AUTO] = ctrl_auto;
          bus_rdata[CTRL_IE]   = ctrl_ie;
`ifdef TIMER_PRESCALE_EN
          bus_rdata[CTRL_PSC_LSB +: PSC_W] = psc_q;
`endif
        end
        TMR_LOAD:   bus_rdata = load_q;
        TMR_COUNT:  bus_rdata = count_q;
        TMR_STATUS: bus_rdata[0] = exp_q;
        default:    bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_timer_unit;

  localparam int unsigned DW = 19;
  localparam logic [1:0] R_CTRL = 2'd0, R_LOAD = 2'd1, R_COUNT = 2'd2, R_STATUS = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bus_valid;
  logic          bus_write;
  logic [DW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          irq_timer;

  int n_tests = 0;
  int n_fail  = 0;

  timer_unit #(.DATA_W(19), .PSC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_en, m_auto, m_ie, m_exp, m_irq;
  int unsigned m_psc, m_load, m_count, m_phase;

  function automatic void model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_irq = 0;
    m_psc = 0; m_load = 0; m_count = 0; m_phase = 0;
  endfunction

  function automatic int unsigned model_read(input logic [1:0] r);
    case (r)
      R_CTRL:   return int'(m_en) | (int'(m_auto) << 1) | (int'(m_ie) << 2) | (m_psc << 8);
      R_LOAD:   return m_load;
      R_COUNT:  return m_count;
      default:  return int'(m_exp);
    endcase
  endfunction

  // One clock edge of the timer, from the register-level rules
  function automatic void model_step(input bit v, input bit w, input logic [1:0] r,
                                     input logic [DW-1:0] d);
    bit wc, wl, ws, tk, ex;
    wc = v && w && (r == R_CTRL);
    wl = v && w && (r == R_LOAD);
    ws = v && w && (r == R_STATUS);
    // a tick every (psc+1)th enabled cycle since the last CTRL write
    tk = m_en && ((m_phase % (m_psc + 1)) == m_psc) && !wc && !wl;
    ex = tk && (m_count == 0);
    m_irq = ex && m_ie;
    if (ex) m_exp = 1;
    else if (ws && d[0]) m_exp = 0;
    if (wl) begin
      m_load = int'(d); m_count = int'(d);
    end else if (tk) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_auto) m_count = m_load;
    end
    if (wc) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2];
`ifdef TIMER_PRESCALE_EN
      m_psc = int'(d[15:8]);
`endif
      m_phase = 0;
    end else begin
      m_phase = m_en ? m_phase + 1 : 0;
      if (ex && !m_auto) m_en = 0;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drives one bus cycle, checks outputs against the model, then clocks
  task automatic do_cycle(input bit rst, input bit v, input bit w, input logic [1:0] r,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic irq);
    logic [DW-1:0] a;
    a = DW'($urandom);
    a[3:2] = r;
    rst_n = !rst; bus_valid = v; bus_write = w; bus_addr = a; bus_wdata = d;
    #2;
    rd = bus_rdata; irq = irq_timer;
    check("irq_model", {31'd0, irq_timer}, {31'd0, m_irq});
    if (v && !w) check("rdata_model", {13'd0, bus_rdata}, model_read(r));
    else         check("rdata_idle",  {13'd0, bus_rdata}, 32'd0);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(v, w, r, d);
    #1;
  endtask

  logic [DW-1:0] rd;
  logic          irq;

  task automatic wr(input logic [1:0] r, input logic [DW-1:0] d);
    do_cycle(0, 1, 1, r, d, rd, irq);
  endtask
  task automatic rdreg(input logic [1:0] r);
    do_cycle(0, 1, 0, r, '0, rd, irq);
  endtask
  task automatic idle();
    do_cycle(0, 0, 0, R_CTRL, '0, rd, irq);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            v;
    bit            w;
    logic [1:0]    r;
    logic [DW-1:0] d;
    bit            chk_rd;
    logic [DW-1:0] exp_rd;
    bit            exp_irq;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [1:0] r, input logic [DW-1:0] d,
                              input logic [DW-1:0] e, input bit ei);
    vec_t t;
    t.v = 1; t.w = w; t.r = r; t.d = d; t.chk_rd = !w; t.exp_rd = e; t.exp_irq = ei;
    return t;
  endfunction

  vec_t tv[17];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pulses;
    int unsigned ld;
    logic [DW-1:0] d;

    rst_n = 0; bus_valid = 0; bus_write = 0; bus_addr = '0; bus_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    do_cycle(1, 0, 0, R_CTRL, '0, rd, irq);
    do_cycle(1, 0, 0, R_CTRL, '0, rd, irq);

    // reset state, then one-shot LOAD=5 / CTRL=0x5
    tv[0]  = mk(0, R_CTRL,   '0, 19'd0, 0);
    tv[1]  = mk(0, R_LOAD,   '0, 19'd0, 0);
    tv[2]  = mk(0, R_COUNT,  '0, 19'd0, 0);
    tv[3]  = mk(0, R_STATUS, '0, 19'd0, 0);
    tv[4]  = mk(1, R_LOAD,   19'd5, 19'd0, 0);
    tv[5]  = mk(1, R_CTRL,   19'h5, 19'd0, 0);
    tv[6]  = mk(0, R_COUNT,  '0, 19'd5, 0);
    tv[7]  = mk(0, R_COUNT,  '0, 19'd4, 0);
    tv[8]  = mk(0, R_COUNT,  '0, 19'd3, 0);
    tv[9]  = mk(0, R_COUNT,  '0, 19'd2, 0);
    tv[10] = mk(0, R_COUNT,  '0, 19'd1, 0);
    tv[11] = mk(0, R_COUNT,  '0, 19'd0, 0);
    tv[12] = mk(0, R_STATUS, '0, 19'd1, 1);
    tv[13] = mk(0, R_CTRL,   '0, 19'h4, 0);
    tv[14] = mk(0, R_COUNT,  '0, 19'd0, 0);
    tv[15] = mk(1, R_STATUS, 19'd1, 19'd0, 0);
    tv[16] = mk(0, R_STATUS, '0, 19'd0, 0);

    for (int i = 0; i < 17; i++) begin
      do_cycle(0, tv[i].v, tv[i].w, tv[i].r, tv[i].d, rd, irq);
      if (tv[i].chk_rd) check($sformatf("tbl_rd[%0d]", i), {13'd0, rd}, {13'd0, tv[i].exp_rd});
      check($sformatf("tbl_irq[%0d]", i), {31'd0, irq}, {31'd0, tv[i].exp_irq});
    end

    // auto-reload LOAD=2: COUNT 2,1,0,2,... and a pulse every 3 cycles
    wr(R_LOAD, 19'd2);
    wr(R_CTRL, 19'h7);
    pulses = 0;
    for (int k = 0; k <= 12; k++) begin
      rdreg(R_COUNT);
      check("auto_count", {13'd0, rd}, 32'(2 - (k % 3)));
      check("auto_irq", {31'd0, irq}, {31'd0, (k > 0 && (k % 3) == 0)});
      if (k >= 1 && irq) pulses++;
    end
    check("auto_pulses", pulses, 4);
    wr(R_CTRL, 19'h0);
    wr(R_STATUS, 19'd1);

    // STATUS clear coincident with expiry: set wins; later clear works
    rdreg(R_STATUS);
    check("exp_cleared", {13'd0, rd}, 32'd0);
    wr(R_LOAD, 19'd2);
    wr(R_CTRL, 19'h7);
    idle();
    idle();
    wr(R_STATUS, 19'd1);
    rdreg(R_STATUS);
    check("exp_set_wins", {13'd0, rd}, 32'd1);
    check("exp_set_irq", {31'd0, irq}, 32'd1);
    wr(R_CTRL, 19'h4);
    wr(R_STATUS, 19'd1);
    rdreg(R_STATUS);
    check("exp_clear", {13'd0, rd}, 32'd0);

    // LOAD=0 with AUTO=1, PSC=0: irq_timer stays high
    wr(R_LOAD, 19'd0);
    wr(R_CTRL, 19'h7);
    for (int k = 0; k <= 5; k++) begin
      idle();
      check("cont_irq", {31'd0, irq}, {31'd0, (k >= 1)});
    end
    wr(R_CTRL, 19'h0);
    idle();
    check("cont_irq_off", {31'd0, irq}, 32'd0);
    wr(R_STATUS, 19'd1);

    // reset asserted while COUNT=3 in auto mode
    wr(R_LOAD, 19'd5);
    wr(R_CTRL, 19'h7);
    idle();
    idle();
    do_cycle(1, 1, 0, R_COUNT, '0, rd, irq);
    check("pre_rst_count", {13'd0, rd}, 32'd3);
    for (int k = 0; k < 8; k++) begin
      rdreg(2'(k % 4));
      check("post_rst_reg", {13'd0, rd}, 32'd0);
      check("post_rst_irq", {31'd0, irq}, 32'd0);
    end

`ifdef TIMER_PRESCALE_EN
    // PSC=3: COUNT decrements every 4 cycles, expiry 8 cycles after enable
    wr(R_LOAD, 19'd1);
    wr(R_CTRL, 19'h305);
    for (int k = 0; k <= 9; k++) begin
      if (k == 7 || k == 9) begin
        rdreg(R_STATUS);
        check("psc_exp", {13'd0, rd}, {31'd0, (k == 9)});
      end else begin
        rdreg(R_COUNT);
        check("psc_count", {13'd0, rd}, (k < 4) ? 32'd1 : 32'd0);
      end
      check("psc_irq", {31'd0, irq}, {31'd0, (k == 8)});
    end
    rdreg(R_CTRL);
    check("psc_ctrl", {13'd0, rd}, 32'h304);
    wr(R_STATUS, 19'd1);
    wr(R_CTRL, 19'h0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      if (op < 2) begin
        do_cycle(1, 1'($urandom), 0, 2'($urandom), '0, rd, irq);
      end else if (op < 40) begin
        idle();
      end else if (op < 60) begin
        rdreg(2'($urandom));
      end else if (op < 75) begin
        d = DW'($urandom);
        d[15:8] = 8'($urandom_range(0, 3));
        d[0] = ($urandom_range(0, 3) != 0);
        wr(R_CTRL, d);
      end else if (op < 85) begin
        ld = $urandom_range(0, 9);
        wr(R_LOAD, (ld > 6) ? 19'd0 : 19'(ld));
      end else if (op < 93) begin
        wr(R_STATUS, DW'($urandom));
      end else begin
        wr(R_COUNT, DW'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
